// File: rtl/pfd_tdc_if.sv
// pfd_tdc_if: bundle of the detector's slow clock inputs, mode select and
// loop-filter facing outputs.
// Qualifier semantics: error_out is meaningful to the loop filter only in a
// cycle where sample_en is high. There is no back-pressure (no ready); the
// consumer must take every qualified sample.
interface pfd_tdc_if #(
  parameter int ERR_W = 12
);
  logic                    ref_clk;
  logic                    fb_clk;
  logic                    mode;
  logic signed [ERR_W-1:0] error_out;
  logic                    sample_en;
  logic                    up;
  logic                    dn;
  logic                    locked;

  // Drives the clocks and the mode and observes the detector outputs.
  modport master (
    output ref_clk, fb_clk, mode,
    input  error_out, sample_en, up, dn, locked
  );

  // The detector itself.
  modport slave (
    input  ref_clk, fb_clk, mode,
    output error_out, sample_en, up, dn, locked
  );
endinterface

// File: rtl/pfd_tdc.sv
// pfd_tdc: phase-frequency detector with time-to-digital measurement.
// ref/fb are synchronised to sys_clk, and rises are detected on the oldest two
// synchroniser bits. A three-state IDLE/UP/DOWN machine counts the cycles
// between the opening and closing rises.
// mode=0 outputs a ternary error (+1/-1/0). mode=1 outputs the signed,
// saturated cycle count once per measurement, with a one-cycle sample_en.
// Optional lock detector: define PFD_LOCK_DETECT_EN to build it. Without the
// macro, locked is tied low.
module pfd_tdc #(
  parameter int SYNC_STAGES = 3,
  parameter int ERR_W       = 12,
  parameter int MAX_CNT     = 2047,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  pfd_tdc_if.slave    bus,
  output logic [1:0]  o_dbg_state
);

  localparam int CNT_W = ERR_W - 1;
  localparam logic [CNT_W:0]   L_MAX_WIDE = (CNT_W + 1)'(MAX_CNT);
  localparam logic [CNT_W-1:0] L_MAX      = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  // Elaboration-time sanity checks on the parameter set.
  if (SYNC_STAGES < 3) begin : g_bad_sync
    $error("pfd_tdc: SYNC_STAGES must be at least 3");
  end
  if (MAX_CNT > (2 ** (ERR_W - 1)) - 1) begin : g_bad_max
    $error("pfd_tdc: MAX_CNT does not fit in ERR_W");
  end
  if (LOCK_COUNT < 1 || LOCK_TOL < 0) begin : g_bad_lock
    $error("pfd_tdc: LOCK_COUNT must be >= 1 and LOCK_TOL >= 0");
  end

  logic [SYNC_STAGES-1:0]  r_ref_sync;
  logic [SYNC_STAGES-1:0]  r_fb_sync;
  logic                    w_ref_rise;
  logic                    w_fb_rise;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [CNT_W:0]          w_cnt_wide;
  logic [CNT_W-1:0]        w_cnt_sat;
  logic                    w_meas_ev;
  logic                    w_meas_neg;
  logic [CNT_W-1:0]        w_meas_mag;
  logic signed [ERR_W-1:0] w_meas_val;
  logic signed [ERR_W-1:0] w_tern;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_sen;
  logic                    r_up;
  logic                    r_dn;

  // Shift both asynchronous inputs into their synchronisers. The oldest bit is
  // the edge-detect history.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_sync <= '0;
      r_fb_sync  <= '0;
    end else begin
      r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], bus.ref_clk};
      r_fb_sync  <= {r_fb_sync[SYNC_STAGES-2:0], bus.fb_clk};
    end
  end

  assign w_ref_rise = ~r_ref_sync[SYNC_STAGES-1] & r_ref_sync[SYNC_STAGES-2];
  assign w_fb_rise  = ~r_fb_sync[SYNC_STAGES-1] & r_fb_sync[SYNC_STAGES-2];

  // Saturating count: widen by one bit so the all-ones case cannot wrap.
  assign w_cnt_wide = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_cnt_sat  = (w_cnt_wide > L_MAX_WIDE) ? L_MAX : w_cnt_wide[CNT_W-1:0];

  // State and counter registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. A closing edge wins over a coincident repeat of the
  // opening edge, which is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_meas_ev   = 1'b0;
    w_meas_neg  = 1'b0;
    w_meas_mag  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_meas_ev = 1'b1;
        end else if (w_ref_rise) begin
          w_state_nxt = ST_UP;
          w_cnt_nxt   = L_ONE;
        end else if (w_fb_rise) begin
          w_state_nxt = ST_DOWN;
          w_cnt_nxt   = L_ONE;
        end
      end
      ST_UP: begin
        if (w_fb_rise) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_meas_ev   = 1'b1;
          w_meas_mag  = r_cnt;
        end else begin
          w_cnt_nxt = w_cnt_sat;
        end
      end
      ST_DOWN: begin
        if (w_ref_rise) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_meas_ev   = 1'b1;
          w_meas_neg  = 1'b1;
          w_meas_mag  = r_cnt;
        end else begin
          w_cnt_nxt = w_cnt_sat;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_meas_val = w_meas_neg ? -$signed({1'b0, w_meas_mag})
                                 :  $signed({1'b0, w_meas_mag});
  assign w_tern = (r_state == ST_UP)   ? ERR_W'(1) :
                  (r_state == ST_DOWN) ? '1        : '0;

  // Output registers: up/dn follow the state, and error_out/sample_en follow
  // the selected mode.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
      r_sen <= 1'b0;
      r_up  <= 1'b0;
      r_dn  <= 1'b0;
    end else begin
      r_up <= (r_state == ST_UP);
      r_dn <= (r_state == ST_DOWN);
      if (!bus.mode) begin
        r_err <= w_tern;
        r_sen <= 1'b1;
      end else begin
        r_sen <= w_meas_ev;
        if (w_meas_ev) begin
          r_err <= w_meas_val;
        end
      end
    end
  end

`ifdef PFD_LOCK_DETECT_EN
  localparam int LK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LK_W-1:0]  L_LK_MAX = LK_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] L_TOL    = CNT_W'(LOCK_TOL);

  logic [LK_W-1:0] r_lock_cnt;
  logic [LK_W-1:0] w_lock_inc;
  logic            r_locked;

  assign w_lock_inc = (r_lock_cnt == L_LK_MAX) ? r_lock_cnt
                                               : r_lock_cnt + LK_W'(1);

  // Lock counter: counts consecutive in-tolerance measurements. Any
  // out-of-tolerance measurement, or pulse-width mode, clears it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (!bus.mode) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (w_meas_ev) begin
      if (w_meas_mag <= L_TOL) begin
        r_lock_cnt <= w_lock_inc;
        r_locked   <= (w_lock_inc == L_LK_MAX);
      end else begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end
    end
  end

  assign bus.locked = r_locked;
`else
  assign bus.locked = 1'b0;
`endif

  assign bus.error_out = r_err;
  assign bus.sample_en = r_sen;
  assign bus.up        = r_up;
  assign bus.dn        = r_dn;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/pfd_tdc.md
# pfd_tdc

Parametrised phase-frequency detector with time-to-digital measurement. It samples the slow reference and feedback clocks on the system clock and runs a three-state UP/DOWN/IDLE detector. It produces either a continuous ternary error (pulse-width mode) or a signed, saturated per-edge phase error in system-clock cycles (measured mode). It sits between the clock inputs and the loop filter, replacing the fixed ternary detector, and adds an optional lock indicator.

## Interface

Parameters:
- `SYNC_STAGES`, 3: synchroniser depth per input, including the edge-detect history bit; minimum 3.
- `ERR_W`, 12: signed width of `error_out`.
- `MAX_CNT`, 2047: saturation magnitude for measured error; must be ≤ 2^(ERR_W-1)-1.
- `LOCK_TOL`, 2: maximum |error| counted as in-lock (measured mode only).
- `LOCK_COUNT`, 16: consecutive in-tolerance measurements required to assert `locked`.

Ports:
- `sys_clk`, in, 1: system clock (100 MHz); the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ref_clk`, in, 1: asynchronous slow reference.
- `fb_clk`, in, 1: asynchronous slow feedback.
- `mode`, in, 1: 0 = pulse-width (ternary) mode, 1 = measured mode; quasi-static.
- `error_out`, out, ERR_W signed: phase error.
- `sample_en`, out, 1: error qualifier for the loop filter.
- `up`, out, 1: registered copy of state==UP.
- `dn`, out, 1: registered copy of state==DOWN.
- `locked`, out, 1: lock indicator.

## Operation

- Each input passes through a `SYNC_STAGES` shift register. A rise is detected when the oldest two bits equal 01.
- States: IDLE, UP, DOWN. Cycle counter `cnt` is ERR_W-1 bits unsigned.
- From IDLE:
  - ref_rise only: go to UP, `cnt`←1.
  - fb_rise only: go to DOWN, `cnt`←1.
  - Both rise together: stay in IDLE; this is a zero-error measurement event.
- In UP with no fb_rise: stay in UP, `cnt`←min(`cnt`+1, MAX_CNT). A repeated ref_rise is ignored (frequency-detect behaviour: the state is held and the count keeps growing).
- In UP with fb_rise: go to IDLE; measurement = +`cnt`. This applies even if ref_rise arrives in the same cycle; that ref edge is dropped.
- DOWN mirrors UP with roles swapped; measurement = −`cnt`.
- Pulse-width mode (`mode`=0):
  - `error_out` = +1 while registered state is UP, −1 in DOWN, 0 in IDLE.
  - `sample_en` = 1 every cycle after reset.
- Measured mode (`mode`=1):
  - On each measurement event, `error_out` ← signed measurement (sign-extended) and `sample_en` pulses high for exactly one cycle.
  - `error_out` holds its value between events.
  - A simultaneous-edge event in IDLE yields `error_out`=0 with a `sample_en` pulse.
- Changing `mode` takes effect on the next cycle. The state machine is unaffected.
- Unused state encoding returns to IDLE on the next cycle.

## Timing

- Reset values: all outputs 0; state IDLE; `cnt` 0; synchronisers 0; lock counter 0.
- Reset asserted mid-measurement aborts it immediately. No `sample_en` pulse is issued for the aborted measurement.
- Input edge to rise detection: `SYNC_STAGES`−1 `sys_clk` edges.
- Rise detection to state change: 1 cycle. State to `up`/`dn`/ternary `error_out`: 1 cycle.
- Closing-edge detection to measured `error_out` and `sample_en`: 1 cycle, both in the same cycle.
- Measured value k = number of `sys_clk` cycles between the opening and closing rise detections. Saturates at ±MAX_CNT with no wrap.
- `sample_en` leaves reset low and is first high 1 cycle after reset release in mode 0.

## Configuration

- `PFD_LOCK_DETECT_EN` defined:
  - A lock counter updates on each measured-mode measurement event.
  - |error| ≤ LOCK_TOL: counter increments, saturating at LOCK_COUNT.
  - Otherwise: counter clears and `locked` deasserts in the same cycle `sample_en` pulses.
  - `locked` asserts in the cycle the counter reaches LOCK_COUNT.
  - In mode 0, the counter clears and `locked` is 0.
- Not defined: `locked` is tied to 0, no lock logic is present, and `LOCK_TOL`/`LOCK_COUNT` are unused.

## Test plan

- Reset, then mode=1; ref rises 5 `sys_clk` cycles before fb → one `sample_en` pulse with `error_out`=+5; `up` high for 5 cycles; `dn` stays 0.
- mode=1, fb leads ref by 7 cycles → `error_out`=−7, single `sample_en` pulse; `error_out` holds −7 until the next event.
- mode=1, ERR_W=6, MAX_CNT=31, fb 40 cycles late with two extra ref edges in between → `error_out`=+31, state held UP throughout, one pulse.
- ref and fb rise in the same `sys_clk` cycle in IDLE → state stays IDLE, `error_out`=0, one `sample_en` pulse; in mode 0, `error_out` stays 0.
- mode=0, ref leads fb by 4 cycles → `error_out`=+1 for exactly 4 cycles then 0; `sample_en` constantly 1; `rst_n` pulsed mid-UP → all outputs 0 immediately.
- With `PFD_LOCK_DETECT_EN`, LOCK_COUNT=16, LOCK_TOL=2: 16 measurements of +1 → `locked`=1 on the 16th pulse; next measurement of +3 → `locked`=0 in that cycle.
